// File: rtl/sha3_block_sequencer.sv
// Feeds pre-padded message chunks into a SHA3 core through its scan buffer and
// sequences core reset/enable per 1088-bit rate block, then presents the digest.
module sha3_block_sequencer #(
  parameter int CHUNK_W          = 136,
  parameter int CHUNKS_PER_BLOCK = 8,
  parameter int PERM_CYCLES      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               scan_shift,
  output logic [CHUNK_W-1:0] scan_data,
  output logic               core_reset,
  output logic               core_enable,
  output logic               digest_valid,
  input  logic               digest_ready,
  output logic [15:0]        blk_count,
  output logic               err
);

  localparam int CNT_W = (CHUNKS_PER_BLOCK > 1) ? $clog2(CHUNKS_PER_BLOCK) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    PERM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] chunk_cnt;
  logic [2:0]       perm_cnt;
  logic             last_q;
  logic             accept;
  logic             chunk_end;
  logic             perm_end;

  // Outputs are gated by reset directly so the core sees a quiet interface
  // during the reset cycle itself, not only from the following edge.
  assign in_ready     = (state == LOAD) && !reset;
  assign core_enable  = (state == PERM) && !reset;
  assign digest_valid = (state == DONE) && !reset;
  assign core_reset   = reset || (state == CLR);
  assign accept       = in_valid && in_ready;
  assign scan_shift   = accept;
  assign scan_data    = in_data;
  assign chunk_end    = (chunk_cnt == CNT_W'(CHUNKS_PER_BLOCK - 1));
  assign perm_end     = (perm_cnt == 3'(PERM_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CLR;
      CLR:  state_nxt = LOAD;
      LOAD: if (accept && chunk_end) state_nxt = PERM;
      PERM: if (perm_end) state_nxt = last_q ? DONE : LOAD;
      DONE: if (digest_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      chunk_cnt <= '0;
      perm_cnt  <= '0;
      last_q    <= 1'b0;
      blk_count <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        CLR: begin
          blk_count <= '0;
          chunk_cnt <= '0;
          perm_cnt  <= '0;
          last_q    <= 1'b0;
        end
        LOAD: begin
          if (accept) begin
            if (chunk_end) begin
              last_q    <= in_last;
              chunk_cnt <= '0;
              perm_cnt  <= '0;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
              // an early in_last is flagged but otherwise ignored
              if (in_last) err <= 1'b1;
            end
          end
        end
        PERM: begin
          if (perm_end) begin
            perm_cnt <= '0;
            if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
          end else begin
            perm_cnt <= perm_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha3_block_sequencer.md
SHA3_BLOCK_SEQUENCER -- requirements
Module: sha3_block_sequencer

Interface
REQ-001 Parameter CHUNK_W, 136, width of one scan chunk.
REQ-002 Parameter CHUNKS_PER_BLOCK, 8, chunks per 1088-bit rate block.
REQ-003 Parameter PERM_CYCLES, 6, core enable cycles per block (24 rounds / 4 rounds per cycle).
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port in_valid  in  1  chunk offered.
REQ-007 Port in_ready  out  1  chunk accepted when in_valid and in_ready are both 1.
REQ-008 Port in_data  in  CHUNK_W  pre-padded message chunk.
REQ-009 Port in_last  in  1  marks the final chunk of the message.
REQ-010 Port scan_shift  out  1  one-cycle strobe; integration gates the core scan clock with it.
REQ-011 Port scan_data  out  CHUNK_W  chunk presented to the input buffer.
REQ-012 Port core_reset  out  1  drives the core reset.
REQ-013 Port core_enable  out  1  drives the core enable.
REQ-014 Port digest_valid  out  1  core digest is final and stable.
REQ-015 Port digest_ready  in  1  consumer has taken the digest.
REQ-016 Port blk_count  out  16  blocks absorbed in the current message.
REQ-017 Port err  out  1  sticky protocol-error flag.

Function
REQ-018 The FSM SHALL have states IDLE, CLR, LOAD, PERM, DONE, encoded in 3 bits.
REQ-019 IDLE: in_ready=0; in_valid=1 -> CLR next cycle; no chunk consumed.
REQ-020 CLR: lasts exactly 1 cycle with core_reset=1, in_ready=0, blk_count cleared to 0; -> LOAD.
REQ-021 LOAD: in_ready=1; each accept sets scan_shift=1 in the same cycle, scan_data=in_data combinationally, chunk counter +1.
REQ-022 scan_shift SHALL be 0 in every cycle without an accept; scan_data SHALL be don't-care then.
REQ-023 The accept of chunk index CHUNKS_PER_BLOCK-1 SHALL latch in_last into last_q, zero the chunk counter, and move to PERM.
REQ-024 PERM: core_enable=1 and in_ready=0 for exactly PERM_CYCLES consecutive cycles, counted by a 3-bit counter.
REQ-025 On the final PERM cycle blk_count SHALL increment, saturating at 16'hFFFF; next state is DONE if last_q=1, else LOAD.
REQ-026 DONE: digest_valid=1, core_enable=0, in_ready=0; digest_ready=1 -> IDLE next cycle.
REQ-027 core_reset SHALL equal reset OR (state==CLR), combinationally.
REQ-028 core_enable SHALL be 1 only in PERM.
REQ-029 in_last=1 on an accept with chunk index != CHUNKS_PER_BLOCK-1 SHALL set err; the chunk is still shifted and the in_last is ignored.
REQ-030 err SHALL clear only on reset.
REQ-031 in_valid stalls in LOAD SHALL hold the chunk counter; PERM is never entered on a partial block.
REQ-032 digest_ready outside DONE SHALL be ignored.
REQ-033 in_valid in DONE SHALL be ignored; the next message starts from IDLE, so DONE->IDLE->CLR costs 2 cycles.

Reset
REQ-034 When reset=1 at a clock edge: state=IDLE, chunk and permutation counters=0, last_q=0, blk_count=0, err=0.
REQ-035 While reset=1: core_reset=1, in_ready=0, scan_shift=0, core_enable=0, digest_valid=0.
REQ-036 Reset in any state, including mid-LOAD or mid-PERM, SHALL abort the message with no further core_enable pulses.

Verification
REQ-037 Single block, in_valid held 1 from cycle 0 with in_last on chunk 7 -> CLR at cycle 1, accepts at cycles 2-9, core_enable at cycles 10-15, digest_valid at cycle 16, blk_count=1.
REQ-038 Three-block message, no stalls -> exactly 18 core_enable cycles, 24 scan_shift strobes, blk_count=3, one digest_valid episode.
REQ-039 Random in_valid gaps in LOAD -> scan_shift count per block exactly 8, core_enable never asserted while the chunk counter != 0.
REQ-040 in_last on chunk 3 -> err=1 and stays 1; message continues until in_last on a chunk 7.
REQ-041 reset at the 3rd PERM cycle -> next cycle IDLE, core_enable=0, blk_count=0, core_reset=1 during reset.
REQ-042 digest_ready held low for 10 cycles in DONE -> digest_valid held, core_enable=0 throughout; release -> IDLE.
